// File: rtl/hex7_pkg.sv
// rtl/hex7_pkg.sv - character codes, segment glyphs, mode type and glyph decoder
package hex7_pkg;

  typedef enum logic {EDIT = 1'b0, SCROLL = 1'b1} mode_t;

  localparam logic [4:0] CH_H     = 5'h10;
  localparam logic [4:0] CH_I     = 5'h11;
  localparam logic [4:0] CH_L     = 5'h12;
  localparam logic [4:0] CH_P     = 5'h13;
  localparam logic [4:0] CH_U     = 5'h14;
  localparam logic [4:0] CH_N     = 5'h15;
  localparam logic [4:0] CH_R     = 5'h16;
  localparam logic [4:0] CH_MINUS = 5'h17;
  localparam logic [4:0] CH_BLANK = 5'h1F;

  // Segment order is a..g from left to right, active low.
  localparam logic [0:6] G_BLANK = 7'b1111111;
  localparam logic [0:6] G_H     = 7'b1001000;
  localparam logic [0:6] G_I     = 7'b1111001;
  localparam logic [0:6] G_L     = 7'b1110001;
  localparam logic [0:6] G_P     = 7'b0011000;
  localparam logic [0:6] G_U     = 7'b1000001;
  localparam logic [0:6] G_N     = 7'b1101010;
  localparam logic [0:6] G_R     = 7'b1111010;
  localparam logic [0:6] G_MINUS = 7'b1111110;

  function automatic logic [0:6] glyph(input logic [4:0] code);
    logic [0:6] g;
    case (code)
      5'h00:    g = 7'b0000001;
      5'h01:    g = 7'b1001111;
      5'h02:    g = 7'b0010010;
      5'h03:    g = 7'b0000110;
      5'h04:    g = 7'b1001100;
      5'h05:    g = 7'b0100100;
      5'h06:    g = 7'b0100000;
      5'h07:    g = 7'b0001111;
      5'h08:    g = 7'b0000000;
      5'h09:    g = 7'b0000100;
      5'h0A:    g = 7'b0001000;
      5'h0B:    g = 7'b1100000;
      5'h0C:    g = 7'b0110001;
      5'h0D:    g = 7'b1000010;
      5'h0E:    g = 7'b0110000;
      5'h0F:    g = 7'b0111000;
      CH_H:     g = G_H;
      CH_I:     g = G_I;
      CH_L:     g = G_L;
      CH_P:     g = G_P;
      CH_U:     g = G_U;
      CH_N:     g = G_N;
      CH_R:     g = G_R;
      CH_MINUS: g = G_MINUS;
      default:  g = G_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - active-low key synchronizer, debouncer and press pulse
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_key_n,
  output logic o_press
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_meta;
  logic          r_sync;
  logic          r_level;
  logic          r_armed;
  logic          r_press;
  logic [CW-1:0] r_cnt;
  logic          w_settled;

  assign w_settled = (r_sync != r_level) && (r_cnt == LAST);
  assign o_press   = r_press;

  // Synchronizer resets to "pressed" and the pulse stays disarmed until a real
  // release is seen, so a key held through reset never fires.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_level <= 1'b1;
      r_armed <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_meta  <= i_key_n;
      r_sync  <= r_meta;
      r_press <= w_settled && r_level && r_armed;
      if (r_sync == r_level) begin
        r_cnt <= '0;
      end else if (w_settled) begin
        r_cnt   <= '0;
        r_level <= r_sync;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_sync && r_level) r_armed <= 1'b1;
    end
  end

endmodule

// File: rtl/hex_text_entry_scroller.sv
// rtl/hex_text_entry_scroller.sv - six-digit text entry (EDIT) and right-to-left scroller (SCROLL)
module hex_text_entry_scroller import hex7_pkg::*; #(
  parameter int CLK_HZ          = 50000000,
  parameter int SCROLL_HZ       = 1,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MAX_LEN         = 16
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [4:0] SW,
  input  logic [2:0] KEY,
  output logic [0:6] HEX0,
  output logic [0:6] HEX1,
  output logic [0:6] HEX2,
  output logic [0:6] HEX3,
  output logic [0:6] HEX4,
  output logic [0:6] HEX5,
  output logic [6:0] LEDR
);
  localparam int TICK_N = CLK_HZ / SCROLL_HZ;
  localparam int TW     = (TICK_N > 1) ? $clog2(TICK_N) : 1;
  localparam int IW     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int BUF_D  = 1 << IW;
  localparam logic [4:0]    LEN_MAX   = 5'(MAX_LEN);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_N - 1);

  logic [2:0]    w_press;
  mode_t         r_mode, w_mode_nxt;
  logic [4:0]    r_len, w_len_nxt;
  logic [5:0]    r_pos, w_pos_nxt;
  logic [TW-1:0] r_tick_cnt, w_cnt_nxt;
  logic          w_wr_en;
  logic          w_tick;
  logic [5:0]    w_last_pos;
  logic [4:0]    r_buf [BUF_D];
  logic [5:0]    w_sidx [6];
  logic [0:6]    w_hex [6];
  logic [0:6]    r_hex [6];
  logic [6:0]    r_ledr;

  for (genvar gi = 0; gi < 3; gi++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
      .i_clk   (CLOCK_50),
      .i_reset (reset),
      .i_key_n (KEY[gi]),
      .o_press (w_press[gi])
    );
  end

  assign w_tick     = (r_mode == SCROLL) && (r_tick_cnt == TICK_LAST);
  assign w_last_pos = {1'b0, r_len} + 6'd5;

  // Priority mode > backspace > write; edits are frozen while scrolling.
  always_comb begin
    w_mode_nxt = r_mode;
    w_len_nxt  = r_len;
    w_pos_nxt  = r_pos;
    w_cnt_nxt  = '0;
    w_wr_en    = 1'b0;
    case (r_mode)
      EDIT: begin
        if (w_press[2]) begin
          if (r_len != 5'd0) w_mode_nxt = SCROLL;
        end else if (w_press[1]) begin
          if (r_len != 5'd0) w_len_nxt = r_len - 5'd1;
        end else if (w_press[0]) begin
          if (r_len != LEN_MAX) begin
            w_wr_en   = 1'b1;
            w_len_nxt = r_len + 5'd1;
          end
        end
      end
      SCROLL: begin
        w_cnt_nxt = w_tick ? '0 : r_tick_cnt + 1'b1;
        if (w_tick) w_pos_nxt = (r_pos == w_last_pos) ? 6'd0 : r_pos + 6'd1;
        if (w_press[2]) begin
          w_mode_nxt = EDIT;
          w_pos_nxt  = 6'd0;
          w_cnt_nxt  = '0;
        end
      end
      default: ;
    endcase
  end

  function automatic logic [5:0] wrap_idx(input logic [5:0] p, input logic [5:0] last);
    return (p > last) ? p - last - 6'd1 : p;
  endfunction

  always_comb begin
    for (int k = 0; k < 6; k++) w_sidx[k] = wrap_idx(r_pos + 6'(k), w_last_pos);
  end

  // Stream index 0..5 is the blank lead-in; index 6+i is buffer entry i.
  always_comb begin
    for (int k = 0; k < 6; k++) w_hex[k] = G_BLANK;
    if (r_mode == EDIT) begin
      w_hex[0] = glyph(SW);
      for (int k = 1; k < 6; k++) begin
        if (r_len >= 5'(k)) w_hex[k] = glyph(r_buf[IW'(r_len - 5'(k))]);
      end
    end else begin
      for (int k = 0; k < 6; k++) begin
        if (w_sidx[k] >= 6'd6) w_hex[5-k] = glyph(r_buf[IW'(w_sidx[k] - 6'd6)]);
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_mode     <= EDIT;
      r_len      <= 5'd0;
      r_pos      <= 6'd0;
      r_tick_cnt <= '0;
      r_ledr     <= 7'd0;
      for (int k = 0; k < 6; k++) r_hex[k] <= G_BLANK;
    end else begin
      r_mode     <= w_mode_nxt;
      r_len      <= w_len_nxt;
      r_pos      <= w_pos_nxt;
      r_tick_cnt <= w_cnt_nxt;
      r_ledr     <= {r_mode == SCROLL, r_len == LEN_MAX, r_len};
      for (int k = 0; k < 6; k++) r_hex[k] <= w_hex[k];
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset && w_wr_en) r_buf[r_len[IW-1:0]] <= SW;
  end

  assign HEX0 = r_hex[0];
  assign HEX1 = r_hex[1];
  assign HEX2 = r_hex[2];
  assign HEX3 = r_hex[3];
  assign HEX4 = r_hex[4];
  assign HEX5 = r_hex[5];
  assign LEDR = r_ledr;

endmodule
